mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-channel valid/ready memory interface that the GPU drives on its data and program memory ports.
- Owns a synchronous backing array of 2^ADDR_BITS words.
- Serves every channel independently with a fixed response latency.
- Used as the synthesizable memory model behind the GPU in system benches and FPGA bring-up.
- Exposes a preload port for program/data images and a debug read port.

Parameters:
- ADDR_BITS, 8, address width; array depth 2^ADDR_BITS.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, number of independent request channels.
- LATENCY, 2, cycles from request acceptance to ready assertion; legal range 1..15.
- WRITE_ENABLE, 1, 0 = read-only: write inputs ignored, write_ready tied 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request.
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS  read address per channel.
- mem_read_ready  out  NUM_CHANNELS  read data valid / acknowledge.
- mem_read_data  out  DATA_BITS x NUM_CHANNELS  read data per channel.
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS  write address.
- mem_write_data  in  DATA_BITS x NUM_CHANNELS  write data.
- mem_write_ready  out  NUM_CHANNELS  write acknowledge.
- load_enable  in  1  preload write strobe.
- load_address  in  ADDR_BITS  preload address.
- load_data  in  DATA_BITS  preload data.
- dbg_address  in  ADDR_BITS  debug read address.
- dbg_data  out  DATA_BITS  combinational array[dbg_address].

Behaviour:

Clock and reset:
- Single clock domain. Reset is synchronous and active-high.
- On reset, all ready outputs = 0, all mem_read_data = 0, and every channel FSM goes to IDLE.
- Array contents are NOT cleared by reset, so the preload survives.
- A reset mid-operation aborts pending requests. A write not yet committed is never committed.

Per-channel FSM (one independent FSM per channel):
- IDLE, read_valid=1: latch address, counter = LATENCY-1, go to BUSY_R. Read has priority over write.
- IDLE, read_valid=0 and write_valid=1 (and WRITE_ENABLE=1): latch address and data, go to BUSY_W.
- BUSY_R / BUSY_W, counter != 0: decrement.
- BUSY_R, counter == 0: capture array[addr] into mem_read_data, set read_ready=1, go to RESP_R.
- BUSY_W, counter == 0: commit array[addr] <= data, set write_ready=1, go to RESP_W.
- RESP_x: ready is held at 1 while the corresponding valid stays 1.
- RESP_x, valid sampled 0: ready=0 on the next cycle, go to IDLE. mem_read_data holds its last value.
- Net timing: ready rises exactly LATENCY cycles after the edge that accepted the request. LATENCY=1 means ready is high in the cycle right after acceptance.
- Minimum turnaround: a new request is accepted no earlier than the IDLE cycle that follows ready's deassertion.
- Valid dropped during BUSY: the request still completes (write commits), ready pulses for exactly one cycle, then IDLE.
- Address and data changes during BUSY/RESP are ignored; latched values are used.

Array write ordering within one cycle:
- Channel writes are applied in ascending index order, so the highest-index channel wins on an address collision.
- load_enable has the lowest priority: it is dropped if any channel commits to the same address that cycle, and applied otherwise.
- A read capture and a write commit to the same address in the same cycle: the read returns the pre-write value.

Read-only mode:
- With WRITE_ENABLE=0, write_valid never causes a state change and mem_write_ready stays 0.

Widths:
- Addresses wrap naturally at 2^ADDR_BITS.
- The latency counter is 4 bits.

Test Plan:
- T1: preload addr 0x10 = 0xA5; ch0 read 0x10 with valid held → mem_read_ready[0] rises exactly 2 cycles after acceptance with data 0xA5; drop valid → ready=0 next cycle.
- T2: ch1 write 0x20 = 0x3C → write_ready[1] after 2 cycles; dbg_address=0x20 → dbg_data=0x3C; ch2 then reads 0x20 → 0x3C.
- T3: all 4 channels read distinct preloaded addresses in the same cycle → all four ready in the same cycle, each with correct data; no cross-channel interference.
- T4: ch0 and ch3 write 0x40 with 0x11 and 0x33, committing in the same cycle, plus load 0x40 = 0x77 → array[0x40] = 0x33.
- T5: ch0 read_valid and write_valid both high in IDLE → read is served first; the write is accepted only after read_ready falls and valid is re-sampled.
- T6: reset asserted while ch2 is in BUSY_W for 0x50 (old value 0x00) → ready stays 0, array[0x50] stays 0x00, and preloaded data is intact. Also run LATENCY=1: ready arrives 1 cycle after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Multi-channel valid/ready memory responder with fixed latency,
//            preload port and combinational debug read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_enable,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data,
  input  logic [ADDR_BITS-1:0]                   dbg_address,
  output logic [DATA_BITS-1:0]                   dbg_data
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_R = 3'd1;
  localparam logic [2:0] S_BUSY_W = 3'd2;
  localparam logic [2:0] S_RESP_R = 3'd3;
  localparam logic [2:0] S_RESP_W = 3'd4;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [2:0]           state_q [NUM_CHANNELS];
  logic [2:0]           state_d [NUM_CHANNELS];
  logic [3:0]           cnt_q   [NUM_CHANNELS];
  logic [3:0]           cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rready_q, rready_d;
  logic [NUM_CHANNELS-1:0] wready_q, wready_d;
  logic [NUM_CHANNELS-1:0] commit_w;

  always_comb begin
    rready_d = rready_q;
    wready_d = wready_q;
    commit_w = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      rdata_d[i] = rdata_q[i];
      case (state_q[i])
        S_IDLE: begin
          // Read wins over a simultaneous write request.
          if (mem_read_valid[i]) begin
            state_d[i] = S_BUSY_R;
            cnt_d[i]   = LAT_M1;
            addr_d[i]  = mem_read_address[i];
          end else if ((WRITE_ENABLE != 0) && mem_write_valid[i]) begin
            state_d[i] = S_BUSY_W;
            cnt_d[i]   = LAT_M1;
            addr_d[i]  = mem_write_address[i];
            wdata_d[i] = mem_write_data[i];
          end
        end
        S_BUSY_R: begin
          if (cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end else begin
            rdata_d[i]  = mem_q[addr_q[i]];
            rready_d[i] = 1'b1;
            state_d[i]  = S_RESP_R;
          end
        end
        S_BUSY_W: begin
          if (cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end else begin
            commit_w[i] = 1'b1;
            wready_d[i] = 1'b1;
            state_d[i]  = S_RESP_W;
          end
        end
        S_RESP_R: begin
          if (!mem_read_valid[i]) begin
            rready_d[i] = 1'b0;
            state_d[i]  = S_IDLE;
          end
        end
        S_RESP_W: begin
          if (!mem_write_valid[i]) begin
            wready_d[i] = 1'b0;
            state_d[i]  = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rready_q <= '0;
      wready_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 4'd0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      rready_q <= rready_d;
      wready_q <= wready_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  // Array is never reset. Later non-blocking writes win, so the preload loses
  // to any channel and higher channels override lower ones on a collision.
  always_ff @(posedge clk) begin
    if (load_enable) begin
      mem_q[load_address] <= load_data;
    end
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (commit_w[i]) begin
          mem_q[addr_q[i]] <= wdata_q[i];
        end
      end
    end
  end

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      mem_read_data[i] = rdata_q[i];
    end
  end

  assign mem_read_ready  = rready_q;
  assign mem_write_ready = (WRITE_ENABLE != 0) ? wready_q : '0;
  assign dbg_data        = mem_q[dbg_address];

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]      rvalid, wvalid, rready, wready;
  logic [3:0][7:0] raddr, waddr, wdata, rdata;
  logic            load_en;
  logic [7:0]      load_addr, load_dat, dbg_addr, dbg_dat;

  // Second instance: LATENCY=1, read-only
  logic [3:0]      rvalid1, wvalid1, rready1, wready1;
  logic [3:0][7:0] raddr1, waddr1, wdata1, rdata1;
  logic            load_en1;
  logic [7:0]      load_addr1, load_dat1, dbg_addr1, dbg_dat1;

  int total = 0;
  int bad   = 0;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rvalid), .mem_read_address(raddr), .mem_read_ready(rready), .mem_read_data(rdata),
    .mem_write_valid(wvalid), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wready),
    .load_enable(load_en), .load_address(load_addr), .load_data(load_dat),
    .dbg_address(dbg_addr), .dbg_data(dbg_dat)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(1), .WRITE_ENABLE(0)) dut1 (
    .clk(clk), .reset(reset),
    .mem_read_valid(rvalid1), .mem_read_address(raddr1), .mem_read_ready(rready1), .mem_read_data(rdata1),
    .mem_write_valid(wvalid1), .mem_write_address(waddr1), .mem_write_data(wdata1), .mem_write_ready(wready1),
    .load_enable(load_en1), .load_address(load_addr1), .load_data(load_dat1),
    .dbg_address(dbg_addr1), .dbg_data(dbg_dat1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_dat = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL rst_rready got=%b exp=%b", rready, 4'h0); end
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL rst_wready got=%b exp=%b", wready, 4'h0); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=%h", rdata, 32'h0); end
    total++; if (rready1 !== 4'h0) begin bad++; $display("FAIL rst_rready1 got=%b exp=%b", rready1, 4'h0); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    rvalid[0] = 1'b1; raddr[0] = 8'h10;
    tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t1_accept got=%b exp=%b", rready, 4'h0); end
    tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t1_early got=%b exp=%b", rready, 4'h0); end
    tick();
    total++; if (rready !== 4'h1) begin bad++; $display("FAIL t1_ready got=%b exp=%b", rready, 4'h1); end
    total++; if (rdata[0] !== 8'hA5) begin bad++; $display("FAIL t1_data got=%h exp=%h", rdata[0], 8'hA5); end
    tick();
    total++; if (rready !== 4'h1) begin bad++; $display("FAIL t1_hold got=%b exp=%b", rready, 4'h1); end
    rvalid[0] = 1'b0;
    tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t1_drop got=%b exp=%b", rready, 4'h0); end
    total++; if (rdata[0] !== 8'hA5) begin bad++; $display("FAIL t1_keep got=%h exp=%h", rdata[0], 8'hA5); end
  endtask

  task automatic test_write_then_read();
    wvalid[1] = 1'b1; waddr[1] = 8'h20; wdata[1] = 8'h3C;
    tick(); tick();
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t2_early got=%b exp=%b", wready, 4'h0); end
    tick();
    total++; if (wready !== 4'h2) begin bad++; $display("FAIL t2_wready got=%b exp=%b", wready, 4'h2); end
    dbg_addr = 8'h20; #1;
    total++; if (dbg_dat !== 8'h3C) begin bad++; $display("FAIL t2_dbg got=%h exp=%h", dbg_dat, 8'h3C); end
    wvalid[1] = 1'b0;
    tick();
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t2_wdrop got=%b exp=%b", wready, 4'h0); end
    rvalid[2] = 1'b1; raddr[2] = 8'h20;
    tick(); tick(); tick();
    total++; if (rready !== 4'h4) begin bad++; $display("FAIL t2_rready got=%b exp=%b", rready, 4'h4); end
    total++; if (rdata[2] !== 8'h3C) begin bad++; $display("FAIL t2_rdata got=%h exp=%h", rdata[2], 8'h3C); end
    rvalid[2] = 1'b0;
    tick();
  endtask

  task automatic test_all_channels();
    logic [3:0][7:0] exp_d;
    exp_d = {8'h84, 8'h63, 8'h42, 8'h21};
    raddr = {8'h04, 8'h03, 8'h02, 8'h01};
    rvalid = 4'hF;
    tick(); tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t3_early got=%b exp=%b", rready, 4'h0); end
    tick();
    total++; if (rready !== 4'hF) begin bad++; $display("FAIL t3_ready got=%b exp=%b", rready, 4'hF); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata[i] !== exp_d[i]) begin bad++; $display("FAIL t3_data ch%0d got=%h exp=%h", i, rdata[i], exp_d[i]); end
    end
    rvalid = 4'h0;
    tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t3_drop got=%b exp=%b", rready, 4'h0); end
  endtask

  task automatic test_write_collision();
    waddr[0] = 8'h40; wdata[0] = 8'h11;
    waddr[3] = 8'h40; wdata[3] = 8'h33;
    wvalid = 4'b1001;
    tick(); tick();
    load_en = 1'b1; load_addr = 8'h40; load_dat = 8'h77;
    tick();
    load_en = 1'b0;
    total++; if (wready !== 4'b1001) begin bad++; $display("FAIL t4_wready got=%b exp=%b", wready, 4'b1001); end
    dbg_addr = 8'h40; #1;
    total++; if (dbg_dat !== 8'h33) begin bad++; $display("FAIL t4_winner got=%h exp=%h", dbg_dat, 8'h33); end
    wvalid = 4'h0;
    tick();
  endtask

  task automatic test_read_priority();
    rvalid[0] = 1'b1; raddr[0] = 8'h10;
    wvalid[0] = 1'b1; waddr[0] = 8'h60; wdata[0] = 8'h5A;
    tick(); tick(); tick();
    total++; if (rready !== 4'h1) begin bad++; $display("FAIL t5_rfirst got=%b exp=%b", rready, 4'h1); end
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t5_wheld got=%b exp=%b", wready, 4'h0); end
    total++; if (rdata[0] !== 8'hA5) begin bad++; $display("FAIL t5_rdata got=%h exp=%h", rdata[0], 8'hA5); end
    rvalid[0] = 1'b0;
    tick();
    total++; if (rready !== 4'h0) begin bad++; $display("FAIL t5_rdrop got=%b exp=%b", rready, 4'h0); end
    tick(); tick();
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t5_wearly got=%b exp=%b", wready, 4'h0); end
    dbg_addr = 8'h60; #1;
    total++; if (dbg_dat !== 8'h00) begin bad++; $display("FAIL t5_precommit got=%h exp=%h", dbg_dat, 8'h00); end
    tick();
    total++; if (wready !== 4'h1) begin bad++; $display("FAIL t5_wready got=%b exp=%b", wready, 4'h1); end
    total++; if (dbg_dat !== 8'h5A) begin bad++; $display("FAIL t5_commit got=%h exp=%h", dbg_dat, 8'h5A); end
    wvalid[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    wvalid[2] = 1'b1; waddr[2] = 8'h50; wdata[2] = 8'hEE;
    tick(); tick();
    reset = 1'b1;
    tick();
    wvalid[2] = 1'b0;
    reset = 1'b0;
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t6_wready got=%b exp=%b", wready, 4'h0); end
    dbg_addr = 8'h50; #1;
    total++; if (dbg_dat !== 8'h00) begin bad++; $display("FAIL t6_nocommit got=%h exp=%h", dbg_dat, 8'h00); end
    tick(); tick(); tick();
    total++; if (dbg_dat !== 8'h00) begin bad++; $display("FAIL t6_late got=%h exp=%h", dbg_dat, 8'h00); end
    total++; if (wready !== 4'h0) begin bad++; $display("FAIL t6_idle got=%b exp=%b", wready, 4'h0); end
    dbg_addr = 8'h10; #1;
    total++; if (dbg_dat !== 8'hA5) begin bad++; $display("FAIL t6_preload got=%h exp=%h", dbg_dat, 8'hA5); end
  endtask

  task automatic test_latency1_readonly();
    load_en1 = 1'b1; load_addr1 = 8'h05; load_dat1 = 8'hC3;
    tick();
    load_en1 = 1'b0;
    rvalid1[0] = 1'b1; raddr1[0] = 8'h05;
    tick();
    total++; if (rready1 !== 4'h0) begin bad++; $display("FAIL l1_accept got=%b exp=%b", rready1, 4'h0); end
    tick();
    total++; if (rready1 !== 4'h1) begin bad++; $display("FAIL l1_ready got=%b exp=%b", rready1, 4'h1); end
    total++; if (rdata1[0] !== 8'hC3) begin bad++; $display("FAIL l1_data got=%h exp=%h", rdata1[0], 8'hC3); end
    rvalid1[0] = 1'b0;
    tick();
    total++; if (rready1 !== 4'h0) begin bad++; $display("FAIL l1_drop got=%b exp=%b", rready1, 4'h0); end
    wvalid1[1] = 1'b1; waddr1[1] = 8'h05; wdata1[1] = 8'h99;
    tick(); tick(); tick();
    total++; if (wready1 !== 4'h0) begin bad++; $display("FAIL ro_wready got=%b exp=%b", wready1, 4'h0); end
    dbg_addr1 = 8'h05; #1;
    total++; if (dbg_dat1 !== 8'hC3) begin bad++; $display("FAIL ro_array got=%h exp=%h", dbg_dat1, 8'hC3); end
    // A read still works while the ignored write request is held
    rvalid1[1] = 1'b1; raddr1[1] = 8'h05;
    tick(); tick();
    total++; if (rready1 !== 4'h2) begin bad++; $display("FAIL ro_read got=%b exp=%b", rready1, 4'h2); end
    rvalid1 = 4'h0; wvalid1 = 4'h0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    rvalid = '0; wvalid = '0; raddr = '0; waddr = '0; wdata = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0; dbg_addr = '0;
    rvalid1 = '0; wvalid1 = '0; raddr1 = '0; waddr1 = '0; wdata1 = '0;
    load_en1 = 1'b0; load_addr1 = '0; load_dat1 = '0; dbg_addr1 = '0;

    test_reset();
    preload(8'h10, 8'hA5);
    preload(8'h01, 8'h21);
    preload(8'h02, 8'h42);
    preload(8'h03, 8'h63);
    preload(8'h04, 8'h84);
    preload(8'h20, 8'h00);
    preload(8'h40, 8'h00);
    preload(8'h50, 8'h00);
    preload(8'h60, 8'h00);

    test_read_latency();
    test_write_then_read();
    test_all_channels();
    test_write_collision();
    test_read_priority();
    test_reset_abort();
    test_latency1_readonly();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
